// File: rtl/sram_march_bist.sv
// March C- built-in self-test engine for a single-port synchronous SRAM.
// Drives the SRAM port from registers, checks returned words and records the
// first miscompare plus a saturating error count.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start after reset
// M0    | up, w0: one write per address
// M1    | up, (r0,w1): cycle A read, cycle B compare + write
// M2    | up, (r1,w0)
// M3    | down, (r0,w1)
// M4    | down, (r1,w0)
// M5    | up, r0: one read per cycle, compared one cycle later
// DRAIN | compares the final M5 read
// DONE  | results held; start launches a new run
module sram_march_bist #(
  parameter int                ADDR_W = 5,
  parameter int                DATA_W = 16,
  parameter int                DEPTH  = 32,
  parameter logic [DATA_W-1:0] BG     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        err_count
);

  // Element states use their March element number as encoding so fail_elem
  // can be taken straight from the state.
  typedef enum logic [3:0] {
    S_M0 = 4'd0, S_M1 = 4'd1, S_M2 = 4'd2, S_M3 = 4'd3, S_M4 = 4'd4,
    S_M5 = 4'd5, S_DRAIN = 4'd6, S_DONE = 4'd7, S_IDLE = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                cmp_pend_q, cmp_pend_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic [7:0]          err_count_q, err_count_d;

  logic                start_acc;
  logic                cmp_en;
  logic [2:0]          cmp_elem;
  logic [ADDR_W-1:0]   cmp_a;
  logic [DATA_W-1:0]   cmp_exp;

  // State, address walk, registered SRAM port and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wr_en_q <= 1'b0;
      mem_din_q   <= '0;
      cmp_pend_q  <= 1'b0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_din_q   <= mem_din_d;
      cmp_pend_q  <= cmp_pend_d;
      cmp_addr_q  <= cmp_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      err_count_q <= err_count_d;
    end
  end

  // Next state: sequence elements, step addresses, wrap only at element ends.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_M0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_M0, S_M5: begin
        if (addr_q == LAST) begin
          state_d = (state_q == S_M0) ? S_M1 : S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_M1, S_M2: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (addr_q == LAST) begin
            state_d = state_t'(state_q + 4'd1);
            addr_d  = (state_q == S_M1) ? '0 : LAST;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_M3, S_M4: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (addr_q == '0) begin
            state_d = state_t'(state_q + 4'd1);
            addr_d  = (state_q == S_M3) ? LAST : '0;
          end else begin
            addr_d = addr_q - ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  // Outputs: SRAM port for the next cycle, compare of returned data, captures.
  always_comb begin
    busy      = (state_q <= S_DRAIN);
    done      = (state_q == S_DONE);
    start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    mem_wr_en_d = 1'b0;
    if (state_d == S_M0)
      mem_wr_en_d = 1'b1;
    else if ((state_d >= S_M1) && (state_d <= S_M4))
      mem_wr_en_d = phase_d;
    mem_din_d = '0;
    if (mem_wr_en_d)
      mem_din_d = ((state_d == S_M1) || (state_d == S_M3)) ? ~BG : BG;
    mem_addr_d = (state_d <= S_M5) ? addr_d : '0;

    // M5 reads are compared one cycle later, against the address then held.
    cmp_pend_d = (state_q == S_M5);
    cmp_addr_d = addr_q;

    cmp_en   = cmp_pend_q || (phase_q && (state_q >= S_M1) && (state_q <= S_M4));
    cmp_elem = cmp_pend_q ? 3'd5 : state_q[2:0];
    cmp_a    = cmp_pend_q ? cmp_addr_q : addr_q;
    cmp_exp  = ((cmp_elem == 3'd2) || (cmp_elem == 3'd4)) ? ~BG : BG;

    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    err_count_d = err_count_q;
    if (start_acc) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_data_d = '0;
      err_count_d = '0;
    end else if (cmp_en && (mem_dout != cmp_exp)) begin
      if (err_count_q != 8'hFF)
        err_count_d = err_count_q + 8'd1;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_a;
        fail_elem_d = cmp_elem;
        fail_data_d = mem_dout;
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_din   = mem_din_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two engines (BG=0 and BG=A5A5) on behavioural
// SRAMs with injectable faults; a March C- reference model fills a scoreboard
// at each start and results are compared when done rises.
module tb_sram_march_bist;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [4:0]  addr0, addr1, faddr0, faddr1;
  logic        wr0, wr1, busy0, busy1, done0, done1, fail0, fail1;
  logic [15:0] din0, din1, dout0, dout1, fdata0, fdata1;
  logic [2:0]  felem0, felem1;
  logic [7:0]  err0, err1;

  sram_march_bist #(.ADDR_W(5), .DATA_W(16), .DEPTH(32), .BG(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(addr0), .mem_wr_en(wr0), .mem_din(din0), .mem_dout(dout0),
    .busy(busy0), .done(done0), .fail(fail0), .fail_addr(faddr0),
    .fail_elem(felem0), .fail_data(fdata0), .err_count(err0)
  );

  sram_march_bist #(.ADDR_W(5), .DATA_W(16), .DEPTH(32), .BG(16'hA5A5)) u_dut_bg (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(addr1), .mem_wr_en(wr1), .mem_din(din1), .mem_dout(dout1),
    .busy(busy1), .done(done1), .fail(fail1), .fail_addr(faddr1),
    .fail_elem(felem1), .fail_data(fdata1), .err_count(err1)
  );

  // fault kinds: 0 none, 1 stuck-at-0 bit flt_bit at flt_a, 2 writes to flt_a also hit flt_a2
  int flt_kind = 0;
  int flt_a    = 0;
  int flt_bit  = 0;
  int flt_a2   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          fail;
    int          addr;
    int          elem;
    logic [15:0] data;
    int          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_fault(input int a, input logic [15:0] v);
    if (flt_kind == 1 && a == flt_a) return v & ~(16'h0001 << flt_bit);
    return v;
  endfunction

  // Behavioural SRAMs: dout updates only on reads, held during writes.
  logic [15:0] mem0 [32];
  logic [15:0] mem1 [32];
  always @(posedge clk) begin
    if (wr0) begin
      mem0[addr0] <= din0;
      if (flt_kind == 2 && int'(addr0) == flt_a) mem0[flt_a2] <= din0;
    end else begin
      dout0 <= rd_fault(int'(addr0), mem0[addr0]);
    end
    if (wr1) begin
      mem1[addr1] <= din1;
      if (flt_kind == 2 && int'(addr1) == flt_a) mem1[flt_a2] <= din1;
    end else begin
      dout1 <= rd_fault(int'(addr1), mem1[addr1]);
    end
  end

  // Algorithmic March C- on a faulty 32-word memory.
  function automatic exp_t ref_run(input logic [15:0] bg);
    exp_t        r;
    logic [15:0] m [32];
    logic [15:0] ev, got, wv;
    int          a;
    r.fail = 1'b0; r.addr = 0; r.elem = 0; r.data = '0; r.err = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 32; k++) begin
        a = (e == 3 || e == 4) ? 31 - k : k;
        if (e > 0) begin
          ev  = (e == 2 || e == 4) ? ~bg : bg;
          got = rd_fault(a, m[a]);
          if (got != ev) begin
            if (!r.fail) begin
              r.fail = 1'b1; r.addr = a; r.elem = e; r.data = got;
            end
            if (r.err != 255) r.err++;
          end
        end
        if (e < 5) begin
          wv   = (e == 1 || e == 3) ? ~bg : bg;
          m[a] = wv;
          if (flt_kind == 2 && a == flt_a) m[flt_a2] = wv;
        end
      end
    end
    return r;
  endfunction

  task automatic score_one(input string who, inout exp_t q[$], input logic f,
                           input logic [4:0] fa, input logic [2:0] fe,
                           input logic [15:0] fd, input logic [7:0] ec);
    exp_t e;
    check({who, "_sb_pending"}, 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check({who, "_fail"}, 32'(f), 32'(e.fail));
      check({who, "_err_count"}, 32'(ec), 32'(e.err));
      if (e.fail) begin
        check({who, "_fail_addr"}, 32'(fa), 32'(e.addr));
        check({who, "_fail_elem"}, 32'(fe), 32'(e.elem));
        check({who, "_fail_data"}, 32'(fd), 32'(e.data));
      end
    end
  endtask

  // Run monitor: busy-cycle index, M0/M1/M2 write data, scoreboard at done.
  int   bcyc = 0;
  int   bidx;
  int   m0_bad = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  assign bidx = busy_prev ? bcyc : 0;

  always @(negedge clk) begin
    busy_prev <= busy0;
    done_prev <= done0;
    if (busy0) begin
      bcyc <= bidx + 1;
      if (bidx < 32) begin
        if (!(wr0 && int'(addr0) == bidx && din0 == 16'h0000))
          m0_bad <= (busy_prev ? m0_bad : 0) + 1;
        else if (!busy_prev)
          m0_bad <= 0;
      end
      if (bidx == 33) begin
        check("bg_m1_wr_en", 32'(wr1), 1);
        check("bg_m1_wdata", 32'(din1), 32'h5A5A);
      end
      if (bidx == 97) check("bg_m2_wdata", 32'(din1), 32'hA5A5);
    end
    if (done0 && !done_prev) begin
      check("run_len", 32'(bcyc), 321);
      check("m0_writes_bad", 32'(m0_bad), 0);
      check("bg_done", 32'(done1), 1);
      score_one("bg0", q0, fail0, faddr0, felem0, fdata0, err0);
      score_one("bgA5", q1, fail1, faddr1, felem1, fdata1, err1);
    end
  end

  task automatic push_exp();
    q0.push_back(ref_run(16'h0000));
    q1.push_back(ref_run(16'hA5A5));
  endtask

  task automatic do_start();
    push_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!done0) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_fail", 32'(fail0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_wr_en", 32'(wr0), 0);
    check("rst_addr", 32'(addr0), 0);
    check("rst_din", 32'(din0), 0);
    check("rst_fail_addr", 32'(faddr0), 0);
    rst = 1'b0;
    @(negedge clk);

    // fault-free run, both backgrounds
    do_start();
    check("busy_after_start", 32'(busy0), 1);
    wait_done("t1");
    check("t1_fail", 32'(fail0), 0);
    check("t1_bg_fail", 32'(fail1), 0);
    check("t1_idle_wr_en", 32'(wr0), 0);
    check("t1_idle_addr", 32'(addr0), 0);
    check("t1_busy", 32'(busy0), 0);
    repeat (3) @(negedge clk);
    check("t1_done_held", 32'(done0), 1);

    // stuck-at-0 bit 3 at address 5
    flt_kind = 1; flt_a = 5; flt_bit = 3;
    do_start();
    wait_done("t2");
    check("t2_fail", 32'(fail0), 1);
    check("t2_fail_addr", 32'(faddr0), 5);
    check("t2_fail_elem", 32'(felem0), 2);
    check("t2_fail_data", 32'(fdata0), 32'hFFF7);
    check("t2_err", 32'(err0), 2);

    // reset in the middle of a run
    flt_kind = 0;
    do_start();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_busy", 32'(busy0), 0);
    check("t4_wr_en", 32'(wr0), 0);
    check("t4_err", 32'(err0), 0);
    check("t4_done", 32'(done0), 0);
    q0.delete();
    q1.delete();
    rst = 1'b0;
    @(negedge clk);
    do_start();
    wait_done("t4b");

    // start held high: ignored while busy, restarts right after done
    push_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done("t5a");
    push_exp();
    @(negedge clk);
    check("t5_restart_busy", 32'(busy0), 1);
    check("t5_restart_done", 32'(done0), 0);
    start = 1'b0;
    wait_done("t5b");

    // decoder alias: writes to 7 also land in 23
    flt_kind = 2; flt_a = 7; flt_a2 = 23;
    do_start();
    wait_done("t6");
    check("t6_fail", 32'(fail0), 1);
    check("t6_fail_addr", 32'(faddr0), 23);
    check("t6_err_nonzero", 32'(err0 >= 8'd1), 1);

    @(negedge clk);
    check("sb_drained", 32'(q0.size() + q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
